// File: rtl/serial_receive.sv
// 8N1 serial receiver: 2-flop synchronized input, mid-bit sampling FSM and a
// one-entry output buffer with a valid/ready handshake, framing and overrun pulses.
module serial_receive #(
  parameter int CLKS_PER_BIT = 4,
  parameter int MSB_FIRST    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_M1   = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  logic          rx_meta_r;
  logic          rx_sync_r;
  logic          rx_s;
  state_t        state_r,      state_nx_s;
  logic [CW-1:0] cnt_r,        cnt_nx_s;
  logic [2:0]    bit_idx_r,    bit_idx_nx_s;
  logic [7:0]    shift_r,      shift_nx_s;
  logic [7:0]    data_out_r,   data_out_nx_s;
  logic          data_valid_r, data_valid_nx_s;
  logic          frame_err_r,  frame_err_nx_s;
  logic          overrun_r,    overrun_nx_s;
  logic          busy_r;

  assign rx_s = rx_sync_r;

  // Two-flop synchronizer for the asynchronous serial line; idles high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
    end
  end

  // Receiver state, counters, shift register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      cnt_r        <= CNT_ZERO;
      bit_idx_r    <= 3'd0;
      shift_r      <= 8'h00;
      data_out_r   <= 8'h00;
      data_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
      overrun_r    <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_nx_s;
      cnt_r        <= cnt_nx_s;
      bit_idx_r    <= bit_idx_nx_s;
      shift_r      <= shift_nx_s;
      data_out_r   <= data_out_nx_s;
      data_valid_r <= data_valid_nx_s;
      frame_err_r  <= frame_err_nx_s;
      overrun_r    <= overrun_nx_s;
      busy_r       <= (state_nx_s != IDLE);
    end
  end

  // Next-state, sampling and delivery decisions.
  always_comb begin
    state_nx_s      = state_r;
    cnt_nx_s        = cnt_r + CNT_ONE;
    bit_idx_nx_s    = bit_idx_r;
    shift_nx_s      = shift_r;
    data_out_nx_s   = data_out_r;
    data_valid_nx_s = data_valid_r & ~data_ready;
    frame_err_nx_s  = 1'b0;
    overrun_nx_s    = 1'b0;
    case (state_r)
      IDLE: begin
        cnt_nx_s = CNT_ZERO;
        if (!rx_s) begin
          state_nx_s = START;
        end else begin
          state_nx_s = IDLE;
        end
      end
      START: begin
        if (cnt_r == HALF_M1) begin
          cnt_nx_s     = CNT_ZERO;
          bit_idx_nx_s = 3'd0;
          if (!rx_s) begin
            state_nx_s = DATA;
          end else begin
            state_nx_s = IDLE;
          end
        end else begin
          state_nx_s = START;
        end
      end
      DATA: begin
        if (cnt_r == BIT_M1) begin
          cnt_nx_s = CNT_ZERO;
          if (MSB_FIRST != 0) begin
            shift_nx_s = {shift_r[6:0], rx_s};
          end else begin
            shift_nx_s = {rx_s, shift_r[7:1]};
          end
          if (bit_idx_r == 3'd7) begin
            state_nx_s = STOP;
          end else begin
            bit_idx_nx_s = bit_idx_r + 3'd1;
          end
        end else begin
          state_nx_s = DATA;
        end
      end
      STOP: begin
        if (cnt_r == BIT_M1) begin
          cnt_nx_s = CNT_ZERO;
          if (rx_s) begin
            state_nx_s = IDLE;
            // A consumer taking the old byte on this edge frees room for the new one.
            if (!data_valid_r || data_ready) begin
              data_out_nx_s   = shift_r;
              data_valid_nx_s = 1'b1;
            end else begin
              overrun_nx_s = 1'b1;
            end
          end else begin
            frame_err_nx_s = 1'b1;
            state_nx_s     = WAIT_HIGH;
          end
        end else begin
          state_nx_s = STOP;
        end
      end
      WAIT_HIGH: begin
        cnt_nx_s = CNT_ZERO;
        if (rx_s) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = WAIT_HIGH;
        end
      end
      default: begin
        state_nx_s = IDLE;
        cnt_nx_s   = CNT_ZERO;
      end
    endcase
  end

  assign data_out   = data_out_r;
  assign data_valid = data_valid_r;
  assign frame_err  = frame_err_r;
  assign overrun    = overrun_r;
  assign busy       = busy_r;

endmodule
